gather_rd_sched: RTL and testbench

//  Shares the single gen_m0 AXI read master between two requesters:
//  req 0 = index/descriptor fetch, req 1 = gather data fetch.

---
 rtl/gather_rd_sched.sv | 128 ++++++++++++
 tb/tb_gather_rd_sched.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gather_rd_sched.sv
// Round-robin read-command scheduler sharing the gen_m0 AXI read master between
// index fetch (req 0) and gather data fetch (req 1). Optional 4 KB guard: SCHED_4K_GUARD_EN.
module gather_rd_sched #(
  parameter int AXI_DW   = 512,
  parameter int AXI_AW   = 64,
  parameter int AXI_MIDW = 1,
  parameter int MAX_OUT  = 8
) (
  input  logic                  axi_clk,
  input  logic                  axi_rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [2*AXI_AW-1:0]   req_addr,
  input  logic [15:0]           req_len,
  output logic [1:0]            rsp_valid,
  output logic [AXI_DW-1:0]     rsp_data,
  output logic                  rsp_last,
  output logic [1:0]            err_sticky,
  input  logic                  err_clr,
  output logic                  sched_idle,
  output logic                  gen_m0_mread,
  output logic [AXI_AW-1:0]     gen_m0_maddr,
  output logic [7:0]            gen_m0_mlen,
  output logic [AXI_MIDW-1:0]   gen_m0_mid,
  input  logic                  gen_m0_saccept,
  input  logic                  gen_m0_svalid,
  input  logic [AXI_DW-1:0]     gen_m0_sdata,
  input  logic [AXI_MIDW-1:0]   gen_m0_sid,
  input  logic                  gen_m0_slast,
  input  logic [2:0]            gen_m0_sresp
);

  localparam int NREQ = 2;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t                 state;
  logic [NREQ-1:0][3:0]   out_cnt;
  logic                   last_gnt;
  logic [NREQ-1:0]        elig;
  logic                   gnt_vld;
  logic                   gnt;
  logic [AXI_AW-1:0]      sel_addr;
  logic [7:0]             sel_len;
  logic                   page_cross;
  logic                   acc;
  logic [NREQ-1:0]        rsp_hit;
  logic [NREQ-1:0]        cnt_inc;
  logic [NREQ-1:0]        cnt_dec;
  logic [NREQ-1:0]        err_set;

  always_comb begin
    for (int i = 0; i < NREQ; i++)
      elig[i] = req_valid[i] && (out_cnt[i] < 4'(MAX_OUT));
    // On a tie the requester that did not win last time goes first.
    gnt      = (&elig) ? ~last_gnt : ~elig[0];
    gnt_vld  = (state == S_IDLE) && (|elig);
    sel_addr = gnt ? req_addr[2*AXI_AW-1:AXI_AW] : req_addr[AXI_AW-1:0];
    sel_len  = gnt ? req_len[15:8] : req_len[7:0];
`ifdef SCHED_4K_GUARD_EN
    page_cross = ({3'b000, sel_addr[11:6]} + {1'b0, sel_len}) > 9'd63;
`else
    page_cross = 1'b0;
`endif
    req_ready = gnt_vld ? (NREQ'(1) << gnt) : '0;
    acc       = (state == S_ISSUE) && gen_m0_saccept;
    for (int i = 0; i < NREQ; i++) begin
      rsp_hit[i] = gen_m0_svalid && (gen_m0_sid == AXI_MIDW'(i));
      cnt_inc[i] = acc && (gen_m0_mid == AXI_MIDW'(i));
      cnt_dec[i] = rsp_hit[i] && gen_m0_slast;
      err_set[i] = (rsp_hit[i] && (gen_m0_sresp != 3'd0)) ||
                   (gnt_vld && page_cross && (gnt == 1'(i)));
    end
  end

  assign rsp_valid  = rsp_hit;
  assign rsp_data   = gen_m0_sdata;
  assign rsp_last   = gen_m0_slast;
  assign sched_idle = (state == S_IDLE) && (out_cnt[0] == 4'd0) && (out_cnt[1] == 4'd0);

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state        <= S_IDLE;
      gen_m0_mread <= 1'b0;
      gen_m0_maddr <= '0;
      gen_m0_mlen  <= '0;
      gen_m0_mid   <= '0;
      last_gnt     <= 1'b1;
    end else begin
      case (state)
        S_IDLE: if (gnt_vld) begin
          if (page_cross) begin
            last_gnt <= gnt;
          end else begin
            gen_m0_maddr <= sel_addr;
            gen_m0_mlen  <= sel_len;
            gen_m0_mid   <= AXI_MIDW'(gnt);
            gen_m0_mread <= 1'b1;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: if (gen_m0_saccept) begin
          gen_m0_mread <= 1'b0;
          last_gnt     <= gen_m0_mid[0];
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Late last-beats after a reset find the counter at zero and are ignored.
  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      out_cnt    <= '0;
      err_sticky <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (cnt_inc[i] && !cnt_dec[i])
          out_cnt[i] <= out_cnt[i] + 4'd1;
        else if (!cnt_inc[i] && cnt_dec[i] && (out_cnt[i] != 4'd0))
          out_cnt[i] <= out_cnt[i] - 4'd1;
        err_sticky[i] <= err_set[i] | (err_sticky[i] & ~err_clr);
      end
    end
  end

endmodule

// File: tb/tb_gather_rd_sched.sv
// Bench for gather_rd_sched: directed scenarios then random traffic, every cycle
// compared against a transaction-level model of the scheduler.
module tb_gather_rd_sched;

  localparam int MAX_OUT = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [127:0] req_addr;
  logic [15:0]  req_len;
  logic [1:0]   rsp_valid;
  logic [511:0] rsp_data;
  logic         rsp_last;
  logic [1:0]   err_sticky;
  logic         err_clr;
  logic         sched_idle;
  logic         mread;
  logic [63:0]  maddr;
  logic [7:0]   mlen;
  logic [0:0]   mid;
  logic         saccept;
  logic         svalid;
  logic [511:0] sdata;
  logic [0:0]   sid;
  logic         slast;
  logic [2:0]   sresp;

  gather_rd_sched #(.AXI_DW(512), .AXI_AW(64), .AXI_MIDW(1), .MAX_OUT(MAX_OUT)) dut (
    .axi_clk(clk), .axi_rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .err_sticky(err_sticky), .err_clr(err_clr), .sched_idle(sched_idle),
    .gen_m0_mread(mread), .gen_m0_maddr(maddr), .gen_m0_mlen(mlen), .gen_m0_mid(mid),
    .gen_m0_saccept(saccept), .gen_m0_svalid(svalid), .gen_m0_sdata(sdata),
    .gen_m0_sid(sid), .gen_m0_slast(slast), .gen_m0_sresp(sresp)
  );

  always #2 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: a pending command slot, per-requester outstanding bursts, last winner.
  bit          m_busy;
  logic [63:0] m_addr;
  logic [7:0]  m_len;
  int          m_id;
  int          m_last;
  int          m_cnt[2];
  logic [1:0]  m_err;

  logic [1:0]  obs_ready, obs_rsp, obs_err;
  logic        obs_mread, obs_idle;
  logic [63:0] obs_maddr;
  logic [7:0]  obs_mlen;
  logic [0:0]  obs_mid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_addr = '0; m_len = '0; m_id = 0; m_last = 1;
    m_cnt[0] = 0; m_cnt[1] = 0; m_err = '0;
  endtask

  function automatic int model_grant();
    bit e0, e1;
    if (m_busy) return -1;
    e0 = req_valid[0] && (m_cnt[0] < MAX_OUT);
    e1 = req_valid[1] && (m_cnt[1] < MAX_OUT);
    if (e0 && e1) return 1 - m_last;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  function automatic bit crosses_page(input logic [63:0] a, input logic [7:0] l);
`ifdef SCHED_4K_GUARD_EN
    return (int'(a[11:6]) + int'(l)) > 63;
`else
    return (a[0] & 1'b0) | (l[0] & 1'b0);
`endif
  endfunction

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic cyc();
    int g;
    logic [1:0] set;
    logic [63:0] ga;
    logic [7:0] gl;
    @(negedge clk);
    g = model_grant();
    obs_ready = req_ready; obs_mread = mread; obs_maddr = maddr; obs_mlen = mlen;
    obs_mid = mid; obs_rsp = rsp_valid; obs_err = err_sticky; obs_idle = sched_idle;
    chk("req_ready", req_ready, (g < 0) ? 64'd0 : 64'(1 << g));
    chk("mread", mread, m_busy);
    chk("maddr", maddr, m_addr);
    chk("mlen", mlen, m_len);
    chk("mid", mid, m_id);
    chk("rsp_valid", rsp_valid, {svalid && sid == 1'b1, svalid && sid == 1'b0});
    chk("rsp_data", rsp_data === sdata, 1);
    chk("rsp_last", rsp_last, slast);
    chk("err_sticky", err_sticky, m_err);
    chk("sched_idle", sched_idle, !m_busy && m_cnt[0] == 0 && m_cnt[1] == 0);
    @(posedge clk);
    if (rst) model_reset();
    else begin
      int inc = -1;
      set = '0;
      if (m_busy && saccept) begin
        m_busy = 0; inc = m_id; m_last = m_id;
      end else if (g >= 0) begin
        ga = req_addr[g*64 +: 64];
        gl = req_len[g*8 +: 8];
        if (crosses_page(ga, gl)) begin
          set[g] = 1'b1; m_last = g;
        end else begin
          m_busy = 1; m_addr = ga; m_len = gl; m_id = g;
        end
      end
      for (int j = 0; j < 2; j++) begin
        bit d = svalid && slast && (int'(sid) == j);
        if (inc == j && !d) m_cnt[j]++;
        else if (inc != j && d && m_cnt[j] > 0) m_cnt[j]--;
      end
      if (svalid && sresp != 3'd0) set[sid] = 1'b1;
      m_err = set | (m_err & ~{2{err_clr}});
    end
    #1;
  endtask

  task automatic beat(input logic id, input logic last, input logic [2:0] resp);
    svalid = 1; sid = id; slast = last; sresp = resp; sdata = {16{$urandom}};
    cyc();
    svalid = 0; slast = 0; sresp = 0;
  endtask

  initial begin
    int n, nr, prev;
    bit alt;
    rst = 1; req_valid = 0; req_addr = '0; req_len = '0; err_clr = 0;
    saccept = 0; svalid = 0; sdata = '0; sid = 0; slast = 0; sresp = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cyc();
    chk("rst_mread", obs_mread, 0);
    chk("rst_idle", obs_idle, 1);
    chk("rst_err", obs_err, 0);
    rst = 0;

    // Single burst from requester 0.
    req_valid = 2'b01; req_addr[63:0] = 64'h1000; req_len[7:0] = 8'd63;
    cyc();
    chk("single_ready", obs_ready, 2'b01);
    req_valid = 0;
    cyc();
    chk("single_mread", obs_mread, 1);
    chk("single_maddr", obs_maddr, 64'h1000);
    chk("single_mlen", obs_mlen, 63);
    chk("single_mid", obs_mid, 0);
    saccept = 1; cyc(); saccept = 0;
    chk("single_busy", obs_idle, 0);
    nr = 0;
    for (int b = 0; b < 64; b++) begin
      beat(1'b0, b == 63, 3'd0);
      if (obs_rsp == 2'b01) nr++;
    end
    cyc();
    chk("single_beats", nr, 64);
    chk("single_idle", obs_idle, 1);

    // Both requesters valid continuously: alternating grants, one per 2 cycles.
    req_valid = 2'b11; req_addr = {64'h2000, 64'h3000}; req_len = {8'd3, 8'd5}; saccept = 1;
    n = 0; prev = -1; alt = 1;
    for (int c = 0; c < 8; c++) begin
      cyc();
      if (obs_ready != 0) begin
        n++;
        if ((c % 2) != 0) alt = 0;
        if (prev >= 0 && int'(obs_ready[1]) == prev) alt = 0;
        prev = int'(obs_ready[1]);
      end
    end
    chk("alt_count", n, 4);
    chk("alt_pattern", alt, 1);
    req_valid = 0; saccept = 0;
    beat(1'b0, 1'b1, 3'd0); beat(1'b0, 1'b1, 3'd0);
    beat(1'b1, 1'b1, 3'd0); beat(1'b1, 1'b1, 3'd0);

    // Requester 1 alone runs into its outstanding limit.
    req_valid = 2'b10; saccept = 1; n = 0;
    for (int c = 0; c < 30; c++) begin cyc(); if (obs_ready[1]) n++; end
    chk("maxout_issues", n, MAX_OUT);
    chk("maxout_held", obs_ready, 2'b00);
    beat(1'b1, 1'b1, 3'd0);
    n = 0;
    for (int c = 0; c < 4; c++) begin cyc(); if (obs_ready[1]) n++; end
    chk("maxout_ninth", n, 1);
    req_valid = 0; saccept = 0;
    for (int b = 0; b < MAX_OUT; b++) beat(1'b1, 1'b1, 3'd0);
    cyc();
    chk("maxout_drained", obs_idle, 1);

    // Slave stalls the command for 5 cycles.
    req_valid = 2'b01; req_addr[63:0] = 64'hABC0; req_len[7:0] = 8'd7;
    cyc();
    req_valid = 2'b11;
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk("stall_mread", obs_mread, 1);
      chk("stall_maddr", obs_maddr, 64'hABC0);
      chk("stall_noregrant", obs_ready, 0);
    end
    req_valid = 0; saccept = 1; cyc(); saccept = 0;
    beat(1'b0, 1'b1, 3'd0);

    // Error response on requester 1; set beats a same-cycle clear.
    err_clr = 1; beat(1'b1, 1'b0, 3'd2); err_clr = 0;
    cyc();
    chk("err_set_over_clr", obs_err, 2'b10);
    err_clr = 1; cyc(); err_clr = 0;
    cyc();
    chk("err_cleared", obs_err, 2'b00);

    // Command that would cross a 4 KB page.
    req_valid = 2'b01; req_addr[63:0] = 64'h0FC0; req_len[7:0] = 8'd1; saccept = 1;
    cyc();
    chk("guard_ready", obs_ready, 2'b01);
    req_valid = 0;
    cyc();
`ifdef SCHED_4K_GUARD_EN
    chk("guard_no_mread", obs_mread, 0);
    chk("guard_err", obs_err, 2'b01);
    err_clr = 1; cyc(); err_clr = 0;
`else
    chk("guard_off_mread", obs_mread, 1);
    chk("guard_off_maddr", obs_maddr, 64'h0FC0);
    chk("guard_off_mlen", obs_mlen, 1);
    saccept = 0;
    beat(1'b0, 1'b1, 3'd0);
`endif
    saccept = 0;

    // Reset while a command is waiting for acceptance.
    req_valid = 2'b10; req_addr[127:64] = 64'h5000; cyc();
    req_valid = 0; cyc();
    chk("rstmid_mread_before", obs_mread, 1);
    rst = 1; cyc(); rst = 0;
    cyc();
    chk("rstmid_mread", obs_mread, 0);
    chk("rstmid_idle", obs_idle, 1);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 149) == 0);
      req_valid = 2'($urandom);
      req_addr  = {$urandom, $urandom, $urandom, $urandom};
      req_len   = 16'($urandom);
      saccept   = ($urandom_range(0, 2) != 0);
      svalid    = $urandom_range(0, 1) == 1;
      sid       = 1'($urandom);
      slast     = ($urandom_range(0, 3) == 0);
      sresp     = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      err_clr   = ($urandom_range(0, 9) == 0);
      sdata     = {16{$urandom}};
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
